// File: rtl/fmdsp_pkg.sv
// Shared mode encodings, latency lookup and clamp helper
// for the FMDSP multiply-accumulate pipeline.
package fmdsp_pkg;

  typedef enum logic [1:0] {
    MODE_LO_LO   = 2'b00,
    MODE_LO_FULL = 2'b01,
    MODE_FULL    = 2'b10,
    MODE_DOT     = 2'b11
  } mode_e;

  function automatic int mode_lat(
    input logic [1:0] m,
    input int         l0,
    input int         l1,
    input int         l2,
    input int         l3
  );
    int r;
    r = l0;
    unique case (m)
      MODE_LO_LO:   r = l0;
      MODE_LO_FULL: r = l1;
      MODE_FULL:    r = l2;
      MODE_DOT:     r = l3;
    endcase
    return r;
  endfunction

  function automatic int lat_max(
    input int l0,
    input int l1,
    input int l2,
    input int l3
  );
    int r;
    r = l0;
    if (l1 > r) r = l1;
    if (l2 > r) r = l2;
    if (l3 > r) r = l3;
    return r;
  endfunction

  // Bit i of the clamp value for a w-bit result; neg selects the rail.
  function automatic logic sat_bit(
    input logic neg,
    input int   i,
    input int   w
  );
    return (i == w - 1) ? neg : !neg;
  endfunction

endpackage

// File: rtl/dsp_mode_mult.sv
// Mode-selected signed product, sign-extended to the
// accumulator width; purely combinational.
module dsp_mode_mult
  import fmdsp_pkg::*;
#(
  parameter int N = 9,
  parameter int M = 9,
  parameter int W = N + M
) (
  input  logic [1:0]          mode,
  input  logic [N-1:0]        aa,
  input  logic [M-1:0]        bb,
  output logic signed [W-1:0] prod
);

  localparam int NL = N / 2 + 1;
  localparam int NH = N - NL;
  localparam int ML = M / 2 + 1;
  localparam int MH = M - ML;

  logic signed [NL-1:0] a_lo;
  logic signed [NH-1:0] a_hi;
  logic signed [N-1:0]  a_f;
  logic signed [ML-1:0] b_lo;
  logic signed [MH-1:0] b_hi;
  logic signed [M-1:0]  b_f;
  logic signed [W-1:0]  p_ll;
  logic signed [W-1:0]  p_lf;
  logic signed [W-1:0]  p_ff;
  logic signed [W-1:0]  p_hh;

  assign a_lo = aa[NL-1:0];
  assign a_hi = aa[N-1:NL];
  assign a_f  = aa;
  assign b_lo = bb[ML-1:0];
  assign b_hi = bb[M-1:ML];
  assign b_f  = bb;

  always_comb begin
    p_ll = W'(a_lo) * W'(b_lo);
    p_lf = W'(a_lo) * W'(b_f);
    p_ff = W'(a_f) * W'(b_f);
    p_hh = W'(a_hi) * W'(b_hi);
    prod = p_ll;
    unique case (mode)
      MODE_LO_LO:   prod = p_ll;
      MODE_LO_FULL: prod = p_lf;
      MODE_FULL:    prod = p_ff;
      MODE_DOT:     prod = p_ll + p_hh;
    endcase
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed MAC: per-mode latency, in-order retire,
// accumulate chain with shift, optional saturation.
module dsp_mac_pipe
  import fmdsp_pkg::*;
#(
  parameter int N    = 9,
  parameter int M    = 9,
  parameter int W    = N + M,
  parameter int SH_W = 2,
  parameter int LAT0 = 1,
  parameter int LAT1 = 2,
  parameter int LAT2 = 4,
  parameter int LAT3 = 2,
  parameter int SAT  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mode,
  input  logic            acc_en,
  input  logic [SH_W-1:0] shift,
  input  logic [N-1:0]    aa,
  input  logic [M-1:0]    bb,
  input  logic [W-1:0]    cc,
  output logic            out_valid,
  output logic [W-1:0]    out,
  output logic [1:0]      out_mode,
  output logic            ovf
);

  localparam int LMAX = lat_max(LAT0, LAT1, LAT2, LAT3);
  localparam int RW   = $clog2(LMAX + 1);

  if (LAT0 < 1 || LAT1 < 1 || LAT2 < 1 || LAT3 < 1) begin : g_bad_lat
    $error("dsp_mac_pipe: every latency must be >= 1");
  end
  if (N < 2 || M < 2) begin : g_bad_width
    $error("dsp_mac_pipe: N and M must be >= 2");
  end

  logic signed [W-1:0] prod;
  logic                accept;
  int                  lat_in;
  logic                rdy_q, rdy_d;
  logic [RW-1:0]       rem_q, rem_d;

  logic [LMAX:1]       vld_q, vld_d;
  logic [LMAX:1]       aen_q, aen_d;
  logic signed [W-1:0] prod_q [1:LMAX];
  logic signed [W-1:0] prod_d [1:LMAX];
  logic signed [W-1:0] cc_q [1:LMAX];
  logic signed [W-1:0] cc_d [1:LMAX];
  logic [SH_W-1:0]     sh_q [1:LMAX];
  logic [SH_W-1:0]     sh_d [1:LMAX];
  logic [1:0]          md_q [1:LMAX];
  logic [1:0]          md_d [1:LMAX];

  logic                r_v, r_aen;
  logic signed [W-1:0] r_prod, r_cc;
  logic [SH_W-1:0]     r_sh;
  logic [1:0]          r_md;

  logic signed [W-1:0] acc_q, acc_d;
  logic                chain_q, chain_d;
  logic signed [W-1:0] addend, res;
  logic signed [W:0]   sum;
  logic [W-1:0]        clip;
  logic                of;

  logic                ov_q, ov_d;
  logic [W-1:0]        out_q, out_d;
  logic [1:0]          om_q, om_d;
  logic                ovf_q, ovf_d;

  dsp_mode_mult #(
    .N (N),
    .M (M),
    .W (W)
  ) u_mult (
    .mode (mode),
    .aa   (aa),
    .bb   (bb),
    .prod (prod)
  );

  // A new op may issue only if it retires strictly after the last one.
  assign lat_in   = mode_lat(mode, LAT0, LAT1, LAT2, LAT3);
  assign in_ready = rdy_q && (int'(rem_q) < lat_in);
  assign accept   = in_valid && in_ready;
  assign rdy_d    = 1'b1;

  always_comb begin
    rem_d = rem_q;
    if (accept) rem_d = RW'(lat_in - 1);
    else if (rem_q != '0) rem_d = rem_q - RW'(1);
  end

  always_comb begin
    vld_d  = '0;
    aen_d  = '0;
    prod_d = '{default: '0};
    cc_d   = '{default: '0};
    sh_d   = '{default: '0};
    md_d   = '{default: '0};
    vld_d[1]  = accept;
    aen_d[1]  = acc_en;
    prod_d[1] = prod;
    cc_d[1]   = cc;
    sh_d[1]   = shift;
    md_d[1]   = mode;
    for (int k = 2; k <= LMAX; k++) begin
      vld_d[k]  = vld_q[k-1];
      aen_d[k]  = aen_q[k-1];
      prod_d[k] = prod_q[k-1];
      cc_d[k]   = cc_q[k-1];
      sh_d[k]   = sh_q[k-1];
      md_d[k]   = md_q[k-1];
    end
  end

  always_comb begin
    r_v    = 1'b0;
    r_aen  = 1'b0;
    r_prod = '0;
    r_cc   = '0;
    r_sh   = '0;
    r_md   = '0;
    for (int k = 1; k <= LMAX; k++) begin
      if (vld_q[k] &&
          mode_lat(md_q[k], LAT0, LAT1, LAT2, LAT3) == k) begin
        r_v    = 1'b1;
        r_aen  = aen_q[k];
        r_prod = prod_q[k];
        r_cc   = cc_q[k];
        r_sh   = sh_q[k];
        r_md   = md_q[k];
      end
    end
  end

  always_comb begin
    addend = (r_aen && chain_q) ? (acc_q >>> r_sh) : r_cc;
    sum    = {addend[W-1], addend} + {r_prod[W-1], r_prod};
    of     = sum[W] ^ sum[W-1];
    for (int i = 0; i < W; i++) clip[i] = sat_bit(sum[W], i, W);
    res     = (SAT != 0 && of) ? clip : sum[W-1:0];
    ov_d    = r_v;
    out_d   = r_v ? res : out_q;
    om_d    = r_v ? r_md : om_q;
    ovf_d   = r_v ? of : ovf_q;
    acc_d   = r_v ? res : acc_q;
    chain_d = r_v ? r_aen : chain_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      rem_q   <= '0;
      vld_q   <= '0;
      aen_q   <= '0;
      for (int k = 1; k <= LMAX; k++) begin
        prod_q[k] <= '0;
        cc_q[k]   <= '0;
        sh_q[k]   <= '0;
        md_q[k]   <= '0;
      end
      acc_q   <= '0;
      chain_q <= 1'b0;
      ov_q    <= 1'b0;
      out_q   <= '0;
      om_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdy_q   <= rdy_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      aen_q   <= aen_d;
      for (int k = 1; k <= LMAX; k++) begin
        prod_q[k] <= prod_d[k];
        cc_q[k]   <= cc_d[k];
        sh_q[k]   <= sh_d[k];
        md_q[k]   <= md_d[k];
      end
      acc_q   <= acc_d;
      chain_q <= chain_d;
      ov_q    <= ov_d;
      out_q   <= out_d;
      om_q    <= om_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = ov_q;
  assign out       = out_q;
  assign out_mode  = om_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: wrap and saturating
// instances share one stimulus stream.
module tb_dsp_mac_pipe;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   mode;
  logic         acc_en;
  logic [1:0]   shift;
  logic [8:0]   aa, bb;
  logic [W-1:0] cc;

  logic         in_ready, out_valid, ovf;
  logic [W-1:0] out;
  logic [1:0]   out_mode;
  logic         s_in_ready, s_out_valid, s_ovf;
  logic [W-1:0] s_out;
  logic [1:0]   s_out_mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.SAT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .acc_en(acc_en), .shift(shift), .aa(aa), .bb(bb),
    .cc(cc), .out_valid(out_valid), .out(out), .out_mode(out_mode),
    .ovf(ovf)
  );

  dsp_mac_pipe #(.SAT(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .mode(mode), .acc_en(acc_en), .shift(shift), .aa(aa), .bb(bb),
    .cc(cc), .out_valid(s_out_valid), .out(s_out),
    .out_mode(s_out_mode), .ovf(s_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] md, input logic ae,
                       input logic [1:0] sh, input logic [8:0] a,
                       input logic [8:0] b, input logic [W-1:0] c);
    mode = md; acc_en = ae; shift = sh;
    aa = a; bb = b; cc = c;
    in_valid = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; mode = 2'b00; acc_en = 1'b0;
    shift = '0; aa = '0; bb = '0; cc = '0;
    step(); step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", out_valid); end
    total++;
    if (out !== '0) begin bad++; $display("FAIL rst_out got=%0d want=0", out); end
    total++;
    if (out_mode !== 2'b00) begin bad++; $display("FAIL rst_mode got=%0d want=0", out_mode); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0b want=0", ovf); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", in_ready); end
    rst = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%0b want=1", in_ready); end
  endtask

  task automatic test_mode00();
    drive(2'b00, 1'b0, 2'd0, 9'h01D, 9'h007, W'(100));
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL m00_ready got=%0b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL m00_early got=%0b want=0", out_valid); end
    step();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL m00_valid got=%0b want=1", out_valid); end
    total++;
    if (out !== W'(79)) begin bad++; $display("FAIL m00_out got=%0d want=79", $signed(out)); end
    total++;
    if (out_mode !== 2'b00) begin bad++; $display("FAIL m00_mode got=%0d want=0", out_mode); end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL m00_pulse got=%0b want=0", out_valid); end
    total++;
    if (out !== W'(79)) begin bad++; $display("FAIL m00_hold got=%0d want=79", $signed(out)); end
  endtask

  task automatic test_mode10();
    drive(2'b10, 1'b0, 2'd0, 9'h100, 9'h0FF, W'(0));
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL m10_early%0d got=%0b want=0", i, out_valid); end
      step();
    end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL m10_valid got=%0b want=1", out_valid); end
    total++;
    if (out !== W'(-65280)) begin bad++; $display("FAIL m10_out got=%0d want=-65280", $signed(out)); end
    total++;
    if (out_mode !== 2'b10) begin bad++; $display("FAIL m10_mode got=%0d want=2", out_mode); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL m10_ovf got=%0b want=0", ovf); end
    step();
  endtask

  task automatic test_back_to_back_acc();
    int ev[5] = '{16, 22, 28, 20, 11};
    int ae[5] = '{1, 1, 1, 1, 0};
    int sh[5] = '{0, 0, 0, 1, 0};
    int cv[5] = '{10, 999, 999, 999, 5};
    for (int c = 0; c < 9; c++) begin
      if (c < 5) begin
        drive(2'b10, 1'(ae[c]), 2'(sh[c]), 9'd2, 9'd3, W'(cv[c]));
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL acc_ready%0d got=%0b want=1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 4) begin
        total++;
        if (out_valid !== 1'b1 || out !== W'(ev[c-4])) begin
          bad++;
          $display("FAIL acc_out%0d got=%0d/v%0b want=%0d/v1", c - 4, $signed(out), out_valid, ev[c-4]);
        end
      end else begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL acc_early%0d got=%0b want=0", c, out_valid); end
      end
    end
    step();
  endtask

  task automatic test_stall();
    drive(2'b10, 1'b0, 2'd0, 9'd1, 9'd1, W'(0));
    step();
    drive(2'b00, 1'b0, 2'd0, 9'd1, 9'd1, W'(7));
    for (int j = 0; j < 3; j++) begin
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready%0d got=%0b want=0", j, in_ready); end
      step();
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%0b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out !== W'(1) || out_mode !== 2'b10) begin
      bad++;
      $display("FAIL stall_first got=%0d/m%0d/v%0b want=1/m2/v1", $signed(out), out_mode, out_valid);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out !== W'(8) || out_mode !== 2'b00) begin
      bad++;
      $display("FAIL stall_second got=%0d/m%0d/v%0b want=8/m0/v1", $signed(out), out_mode, out_valid);
    end
  endtask

  task automatic test_dot();
    drive(2'b11, 1'b0, 2'd0, 9'h043, 9'h1E4, W'(0));
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL dot_early0 got=%0b want=0", out_valid); end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL dot_early1 got=%0b want=0", out_valid); end
    step();
    total++;
    if (out_valid !== 1'b1 || out !== W'(10) || out_mode !== 2'b11) begin
      bad++;
      $display("FAIL dot_out got=%0d/m%0d/v%0b want=10/m3/v1", $signed(out), out_mode, out_valid);
    end
    step();
  endtask

  task automatic test_saturation();
    int ew[3] = '{131071, -131067, 126864};
    int es[3] = '{131071, 131071, -131072};
    int eo[3] = '{0, 1, 1};
    for (int c = 0; c < 7; c++) begin
      if (c == 0) drive(2'b10, 1'b1, 2'd0, 9'd2, 9'd3, W'(131065));
      else if (c == 1) drive(2'b10, 1'b1, 2'd0, 9'd2, 9'd3, W'(0));
      else if (c == 2) drive(2'b10, 1'b0, 2'd0, 9'h100, 9'h0FF, W'(-70000));
      else in_valid = 1'b0;
      step();
      if (c >= 4) begin
        total++;
        if (out_valid !== 1'b1 || out !== W'(ew[c-4]) || ovf !== 1'(eo[c-4])) begin
          bad++;
          $display("FAIL wrap%0d got=%0d/o%0b want=%0d/o%0d", c - 4, $signed(out), ovf, ew[c-4], eo[c-4]);
        end
        total++;
        if (s_out_valid !== 1'b1 || s_out !== W'(es[c-4]) || s_ovf !== 1'(eo[c-4])) begin
          bad++;
          $display("FAIL sat%0d got=%0d/o%0b want=%0d/o%0d", c - 4, $signed(s_out), s_ovf, es[c-4], eo[c-4]);
        end
      end
    end
    step();
  endtask

  task automatic test_reset_midflight();
    drive(2'b00, 1'b1, 2'd0, 9'd1, 9'd1, W'(0));
    step();
    in_valid = 1'b0;
    step();
    total++;
    if (out !== W'(1)) begin bad++; $display("FAIL mid_seed got=%0d want=1", $signed(out)); end
    for (int c = 0; c < 3; c++) begin
      drive(2'b10, 1'b1, 2'd0, 9'd2, 9'd3, W'(5));
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (out !== '0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst got=%0d/v%0b want=0/v0", $signed(out), out_valid);
    end
    #4;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_squash%0d got=%0b want=0", c, out_valid); end
    end
    drive(2'b00, 1'b1, 2'd0, 9'd1, 9'd1, W'(40));
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b1 || out !== W'(41)) begin
      bad++;
      $display("FAIL mid_first_cc got=%0d/v%0b want=41/v1", $signed(out), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_mode10();
    test_back_to_back_acc();
    test_stall();
    test_dot();
    test_saturation();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
